// File: rtl/vec_pkg.sv
// Shared types and constants for the vector item sequencer.
//   VEC_ITEMS : items per vector register (must be <= 32)
//   ITEM_W    : width of one item in bits
//   IDX_W     : width of element indices and item counts
//   item_t    : one vector element
//   vec_t     : whole vector register, packed [VEC_ITEMS-1:0][ITEM_W-1:0]
//   seq_state_e : sequencer FSM states
package vec_pkg;

    localparam int unsigned VEC_ITEMS = 20;
    localparam int unsigned ITEM_W    = 32;
    localparam int unsigned IDX_W     = 5;

    typedef logic [ITEM_W-1:0] item_t;
    typedef item_t [VEC_ITEMS-1:0] vec_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } seq_state_e;

endpackage

// File: rtl/vec_item_select.sv
// Combinational VEC_ITEMS:1 item-select mux.
// Ports:
//   vec_i   : source vector
//   index_i : element index; an index >= VEC_ITEMS selects the top element
//   item_o  : selected element
module vec_item_select
    import vec_pkg::*;
(
    input  vec_t             vec_i,
    input  logic [IDX_W-1:0] index_i,
    output item_t            item_o
);

    always_comb begin
        // Default covers out-of-range indices.
        item_o = vec_i[VEC_ITEMS-1];
        for (int k = 0; k < VEC_ITEMS; k++) begin
            if (index_i == IDX_W'(k)) begin
                item_o = vec_i[k];
            end
        end
    end

endmodule

// File: rtl/vector_item_sequencer.sv
// Streams selected elements of a snapshotted vector register one item per cycle over a
// valid/ready interface. On an accepted start the vector is captured, then indices are
// walked from base by stride (modulo VEC_ITEMS) for count items.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   start_i, abort_i  : begin a sequence (IDLE only) / cancel (abort wins over start)
//   base_i, stride_i, count_i : sequence parameters, sampled with an accepted start
//   vector_i          : source vector, captured with an accepted start
//   item_data_o, item_index_o, item_last_o, item_valid_o, item_ready_i : item stream
//   busy_o            : sequence in progress
//   done_o            : one-cycle pulse after the final handshake
//   err_o             : one-cycle pulse after a start with illegal parameters
module vector_item_sequencer
    import vec_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [IDX_W-1:0] base_i,
    input  logic [IDX_W-1:0] stride_i,
    input  logic [IDX_W-1:0] count_i,
    input  vec_t             vector_i,
    output item_t            item_data_o,
    output logic [IDX_W-1:0] item_index_o,
    output logic             item_last_o,
    output logic             item_valid_o,
    input  logic             item_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    localparam logic [IDX_W-1:0] ItemsIdx  = IDX_W'(VEC_ITEMS);
    localparam logic [IDX_W:0]   ItemsWide = (IDX_W + 1)'(VEC_ITEMS);

    seq_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] rem_q, rem_d;
    logic [IDX_W-1:0] stride_q, stride_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    vec_t             snap_q;
    logic             snap_en;

    logic             params_ok;
    logic             handshake;
    logic [IDX_W:0]   idx_sum;
    logic [IDX_W-1:0] idx_next;
    item_t            sel_item;

    assign params_ok = (base_i < ItemsIdx) && (stride_i < ItemsIdx) &&
                       (count_i != '0) && (count_i <= ItemsIdx);

    assign handshake = item_valid_o && item_ready_i;

    // One extra bit so idx + stride (each < VEC_ITEMS) cannot overflow before the wrap.
    assign idx_sum  = {1'b0, idx_q} + {1'b0, stride_q};
    assign idx_next = (idx_sum >= ItemsWide) ? IDX_W'(idx_sum - ItemsWide) : IDX_W'(idx_sum);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rem_d    = rem_q;
        stride_d = stride_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        snap_en  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i && !abort_i) begin
                    if (params_ok) begin
                        snap_en  = 1'b1;
                        idx_d    = base_i;
                        rem_d    = count_i;
                        stride_d = stride_i;
                        state_d  = EMIT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (handshake) begin
                    if (rem_q == IDX_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_next;
                        rem_d = rem_q - IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            rem_q    <= '0;
            stride_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rem_q    <= rem_d;
            stride_q <= stride_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Snapshot contents are don't-care out of reset, so no reset term.
    always_ff @(posedge clk_i) begin
        if (snap_en) begin
            snap_q <= vector_i;
        end
    end

    vec_item_select u_select (
        .vec_i   (snap_q),
        .index_i (idx_q),
        .item_o  (sel_item)
    );

    // All outputs derive from registered state only; item_ready_i never reaches them.
    always_comb begin
        item_valid_o = (state_q == EMIT);
        busy_o       = item_valid_o;
        item_data_o  = item_valid_o ? sel_item : '0;
        item_index_o = item_valid_o ? idx_q : '0;
        item_last_o  = item_valid_o && (rem_q == IDX_W'(1));
        done_o       = done_q;
        err_o        = err_q;
    end

endmodule

// File: tb/tb_vector_item_sequencer.sv
module tb_vector_item_sequencer;
    import vec_pkg::*;

    logic       clk = 1'b0;
    logic       rst, start, abort, item_ready;
    logic [4:0] base, stride, count;
    vec_t       vector;
    item_t      item_data;
    logic [4:0] item_index;
    logic       item_last, item_valid, busy, done, err;

    vector_item_sequencer dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .abort_i      (abort),
        .base_i       (base),
        .stride_i     (stride),
        .count_i      (count),
        .vector_i     (vector),
        .item_data_o  (item_data),
        .item_index_o (item_index),
        .item_last_o  (item_last),
        .item_valid_o (item_valid),
        .item_ready_i (item_ready),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] index;
        item_t      data;
        logic       last;
    } exp_item_t;

    typedef struct {
        logic [4:0] base;
        logic [4:0] stride;
        logic [4:0] count;
        int         mode;       // 0: ready high, 1: ready 1,0,0 pattern, 2: random ready
        bit         overwrite;  // scramble vector every cycle after start
        bit         poke;       // drive random starts while busy
        bit         exp_err;
    } vec_case_t;

    exp_item_t sb[$];
    exp_item_t e;
    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on each handshake and checks hold-under-stall.
    logic       prev_stall = 1'b0;
    item_t      prev_data;
    logic [4:0] prev_idx;
    logic       prev_last;

    always @(negedge clk) begin
        if (prev_stall) begin
            chk("hold_valid", item_valid, 1);
            chk("hold_data", item_data, prev_data);
            chk("hold_index", item_index, prev_idx);
            chk("hold_last", item_last, prev_last);
        end
        if (item_valid && item_ready && !abort && !rst) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_item: got index %0d, none expected", item_index);
            end else begin
                e = sb.pop_front();
                chk("item_index", item_index, e.index);
                chk("item_data", item_data, e.data);
                chk("item_last", item_last, e.last);
            end
        end
        prev_stall = item_valid && !item_ready && !abort && !rst;
        prev_data  = item_data;
        prev_idx   = item_index;
        prev_last  = item_last;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_ramp;
        for (int k = 0; k < VEC_ITEMS; k++) vector[k] = k * 32'h11;
    endtask

    task automatic push_model(input int b, input int s, input int c);
        int idx;
        exp_item_t x;
        idx = b;
        for (int k = 0; k < c; k++) begin
            x.index = idx[4:0];
            x.data  = vector[idx];
            x.last  = (k == c - 1);
            sb.push_back(x);
            idx = (idx + s) % VEC_ITEMS;
        end
    endtask

    task automatic run_case(input vec_case_t tc);
        int cyc;
        fill_ramp();
        base   = tc.base;
        stride = tc.stride;
        count  = tc.count;
        start  = 1'b1;
        if (!tc.exp_err) push_model(tc.base, tc.stride, tc.count);
        tick();
        start = 1'b0;
        chk("err", err, tc.exp_err);
        chk("busy_after_start", busy, !tc.exp_err);
        chk("valid_after_start", item_valid, !tc.exp_err);
        chk("done_idle", done, 0);
        if (tc.exp_err) begin
            tick();
            chk("err_single_pulse", err, 0);
            chk("busy_after_err", busy, 0);
            chk("valid_after_err", item_valid, 0);
            return;
        end
        cyc = 0;
        while (sb.size() > 0 && cyc < 200) begin
            case (tc.mode)
                0:       item_ready = 1'b1;
                1:       item_ready = (cyc % 3 == 0);
                default: item_ready = 1'($urandom_range(0, 1));
            endcase
            if (tc.overwrite) for (int k = 0; k < VEC_ITEMS; k++) vector[k] = $urandom;
            if (tc.poke) begin
                start  = 1'($urandom_range(0, 1));
                base   = 5'($urandom_range(0, 19));
                stride = 5'($urandom_range(0, 19));
                count  = 5'($urandom_range(1, 20));
            end
            tick();
            cyc++;
        end
        start      = 1'b0;
        item_ready = 1'b0;
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: %0d items outstanding, required 0", sb.size());
            sb.delete();
        end
        chk("done", done, 1);
        chk("busy_in_done", busy, 0);
        chk("valid_in_done", item_valid, 0);
        if (tc.mode == 0) chk("latency", cyc, tc.count);
    endtask

    vec_case_t cases[10];

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cases[0] = '{5'd3,  5'd1,  5'd4,  0, 1'b0, 1'b0, 1'b0};
        cases[1] = '{5'd18, 5'd5,  5'd5,  0, 1'b0, 1'b0, 1'b0};
        cases[2] = '{5'd7,  5'd0,  5'd3,  0, 1'b0, 1'b0, 1'b0};
        cases[3] = '{5'd0,  5'd3,  5'd20, 1, 1'b0, 1'b0, 1'b0};
        cases[4] = '{5'd2,  5'd7,  5'd9,  2, 1'b1, 1'b1, 1'b0};
        cases[5] = '{5'd20, 5'd1,  5'd1,  0, 1'b0, 1'b0, 1'b1};
        cases[6] = '{5'd0,  5'd20, 5'd1,  0, 1'b0, 1'b0, 1'b1};
        cases[7] = '{5'd0,  5'd1,  5'd0,  0, 1'b0, 1'b0, 1'b1};
        cases[8] = '{5'd0,  5'd1,  5'd21, 0, 1'b0, 1'b0, 1'b1};
        cases[9] = '{5'd19, 5'd19, 5'd20, 2, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; abort = 1'b0; item_ready = 1'b0;
        base = '0; stride = '0; count = '0;
        fill_ramp();
        repeat (3) tick();
        chk("rst_valid", item_valid, 0);
        chk("rst_last", item_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_data", item_data, 0);
        chk("rst_index", item_index, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) run_case(cases[i]);

        // Abort in IDLE beats start: no sequence, no err.
        base = 5'd0; stride = 5'd1; count = 5'd2;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("idle_abort_err", err, 0);
        chk("idle_abort_busy", busy, 0);
        tick();
        chk("idle_abort_busy2", busy, 0);

        // Abort after the second handshake.
        fill_ramp();
        base = 5'd0; stride = 5'd2; count = 5'd6;
        start = 1'b1;
        push_model(0, 2, 6);
        tick();
        start = 1'b0; item_ready = 1'b1;
        tick();
        tick();
        item_ready = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", item_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_consumed", 32'(sb.size()), 4);
        sb.delete();
        run_case('{5'd1, 5'd4, 5'd5, 0, 1'b0, 1'b0, 1'b0});

        // Reset mid-sequence.
        tick();
        fill_ramp();
        base = 5'd5; stride = 5'd3; count = 5'd8;
        start = 1'b1;
        push_model(5, 3, 8);
        tick();
        start = 1'b0; item_ready = 1'b1;
        tick();
        item_ready = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", item_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_last", item_last, 0);
        chk("midrst_data", item_data, 0);
        chk("midrst_index", item_index, 0);
        sb.delete();
        run_case('{5'd12, 5'd9, 5'd7, 1, 1'b0, 1'b0, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vector_item_sequencer.md
# vector_item_sequencer

Streams selected elements of a 20-item vector register out one item per cycle over a valid/ready interface. On `start` it snapshots the whole vector, then walks element indices from `base` with a programmable `stride`, wrapping modulo I, for `count` items. It sits between the vector register file and scalar consumers such as reduction units and the memory store path. It replaces ad-hoc address driving of the item-select mux with a sequenced, back-pressurable stream.

## Interface
- I, 20: items per vector (must be ≤ 32)
- L, 32: item width in bits
- AW, 5: index/count width
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a sequence (sampled only in IDLE)
- abort  in  1  cancel current sequence
- base  in  AW  first element index
- stride  in  AW  index increment per item
- count  in  AW  number of items to emit
- vector  in  I×L (packed [I-1:0][L-1:0])  source vector, sampled at accepted start
- item_data  out  L  current element
- item_index  out  AW  index of current element
- item_last  out  1  current item is final of sequence
- item_valid  out  1  item_data/item_index/item_last valid
- item_ready  in  1  consumer accepts item
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse after final handshake
- err  out  1  one-cycle pulse on rejected start

## Operation
- States: IDLE, EMIT.
- IDLE + start + !abort, parameters legal: latch vector into snapshot, idx←base, remaining←count, go EMIT.
- Legal parameters: base < I, stride < I, 1 ≤ count ≤ I. Otherwise err=1 for one cycle, remain IDLE, snapshot unchanged.
- stride = 0 is legal and repeats element `base` count times.
- EMIT: item_valid=1, item_data=snapshot[idx], item_index=idx, item_last=(remaining==1).
- Handshake = item_valid & item_ready. On handshake with remaining>1: idx←(idx+stride ≥ I) ? idx+stride−I : idx+stride, remaining−1. Compute the sum in AW+1 bits so it cannot overflow.
- On handshake with remaining==1: go IDLE, done=1 next cycle.
- No handshake: all item outputs held stable (AXI-style; valid is never withdrawn except by abort/rst).
- abort in EMIT: go IDLE next cycle, item_valid=0, done not pulsed. abort in IDLE has priority over start (start ignored, no err).
- start while busy: ignored.
- vector changes after an accepted start do not affect the stream.

## Timing
- Reset values: item_valid=0, item_last=0, busy=0, done=0, err=0, item_data=0, item_index=0. Snapshot contents are don't-care.
- rst mid-sequence: all outputs at reset values after the edge, no done.
- Start accepted at edge t: item_valid=1 and busy=1 from cycle t+1 with element base.
- With item_ready held high: one item per cycle, last item at t+count, done=1 and busy=0 in cycle t+count+1.
- The earliest next start is sampled in the done cycle (back-to-back sequences with one idle cycle).
- err asserts in cycle t+1 for a start rejected at edge t.
- item_data comes from registered idx through the select mux. There is no combinational path from item_ready to any output.

## Structure
- Shared package `vec_pkg`: VEC_ITEMS=20, ITEM_W=32, IDX_W=5, typedef `item_t` (logic [ITEM_W-1:0]), typedef `vec_t` (item_t [VEC_ITEMS-1:0]), enum `seq_state_e` {IDLE, EMIT}.
- Sub-module `vec_item_select`: combinational I:1 mux (vec_t, index → item_t), index ≥ I selects item I−1. It is instantiated once on the snapshot.
- Top level holds the FSM, idx/remaining counters, snapshot register and output flags.

## Test plan
- Vector[k]=k*0x11, base=3, stride=1, count=4, ready=1 → indices 3,4,5,6, data 0x33,0x44,0x55,0x66, last on 4th item, done one cycle later.
- Wrap: base=18, stride=5, count=5 → indices 18,3,8,13,. 18 with last on final item; stride 0, count=3 → index 7 three times.
- Back-pressure: ready toggles 1,0,0,1,… → outputs stable while ready=0, no item lost or duplicated, total handshakes = count.
- Vector overwritten every cycle after start → streamed data equals values at start edge.
- Illegal starts: base=20, stride=20, count=0, count=21 → err pulse each, busy stays 0, item_valid stays 0.
- Abort after 2nd handshake and rst mid-sequence → item_valid=0 next cycle, no done, new start accepted immediately after.
